// File: rtl/prio_aging_pkg.sv
// Shared types and helpers for the priority aging unit and its per-requester lanes.
package prio_aging_pkg;

    localparam int unsigned NREQ     = 3;
    localparam int unsigned PRIO_W   = 2;
    localparam int unsigned PRIO_MAX = 3;
    localparam int unsigned SUM_W    = PRIO_W + 1;

    typedef logic [PRIO_W-1:0] prio_t;

    // Base plus boost formed one bit wider, then clamped to the top level.
    function automatic prio_t prio_sat_add(input prio_t base, input prio_t boost);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, base} + {1'b0, boost};
        return (sum > SUM_W'(PRIO_MAX)) ? PRIO_W'(PRIO_MAX) : sum[PRIO_W-1:0];
    endfunction

endpackage

// File: rtl/prio_age_lane.sv
// Single-requester aging lane: wait counter, priority boost and sticky starvation flag.
module prio_age_lane
    import prio_aging_pkg::*;
#(
    parameter int unsigned AGE_THRESH = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              age_en,
    input  logic [PRIO_W-1:0] base_prio_i,
    input  logic              req_i,
    input  logic              gnt_i,
    output logic [PRIO_W-1:0] prio_c_o,
    output logic              starve_o
);

    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [PRIO_W-1:0] boost_q,  boost_d;
    logic              starve_q, starve_d;

    assign prio_c_o = prio_sat_add(base_prio_i, boost_q);
    assign starve_o = starve_q;

    // Grant and withdrawal both discard age; otherwise age while enabled.
    always_comb begin
        cnt_d    = cnt_q;
        boost_d  = boost_q;
        starve_d = starve_q;
        if (gnt_i || !req_i) begin
            cnt_d    = '0;
            boost_d  = '0;
            starve_d = 1'b0;
        end else if (age_en) begin
            if (cnt_q < CNT_W'(AGE_THRESH - 1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = '0;
                if (prio_c_o != PRIO_W'(PRIO_MAX)) begin
                    boost_d = boost_q + PRIO_W'(1);
                end else begin
                    starve_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            boost_q  <= '0;
            starve_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            boost_q  <= boost_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/prio_aging_unit.sv
// Priority aging front end for the 3-requester arbiter: one aging lane per requester.
// Optional macro PRIO_AGING_ASSERT_EN adds simulation-only protocol and state assertions.
module prio_aging_unit
    import prio_aging_pkg::*;
#(
    parameter int unsigned AGE_THRESH = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            age_en,
    input  logic [1:0]      base_prio0,
    input  logic [1:0]      base_prio1,
    input  logic [1:0]      base_prio2,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] gnt,
    output logic [1:0]      prio0,
    output logic [1:0]      prio1,
    output logic [1:0]      prio2,
    output logic [NREQ-1:0] starve
);

    logic [PRIO_W-1:0] base_a [NREQ];
    logic [PRIO_W-1:0] prio_a [NREQ];

    assign base_a[0] = base_prio0;
    assign base_a[1] = base_prio1;
    assign base_a[2] = base_prio2;

    assign prio0 = prio_a[0];
    assign prio1 = prio_a[1];
    assign prio2 = prio_a[2];

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        prio_age_lane #(
            .AGE_THRESH (AGE_THRESH),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .age_en      (age_en),
            .base_prio_i (base_a[i]),
            .req_i       (req[i]),
            .gnt_i       (gnt[i]),
            .prio_c_o    (prio_a[i]),
            .starve_o    (starve[i])
        );

`ifdef PRIO_AGING_ASSERT_EN
        a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
            !(gnt[i] && |(gnt & ~(NREQ'(1) << i))))
            else $error("prio_aging_unit lane %0d: granted together with another lane (gnt=%b)", i, gnt);
        a_gnt_req: assert property (@(posedge clk) disable iff (!rst_n) gnt[i] |-> req[i])
            else $error("prio_aging_unit lane %0d: grant without request", i);
        a_state: assert property (@(posedge clk) disable iff (!rst_n)
            (u_lane.boost_q <= PRIO_W'(PRIO_MAX)) && (32'(u_lane.cnt_q) < AGE_THRESH))
            else $error("prio_aging_unit lane %0d: boost/counter out of range", i);
        a_starve_top: assert property (@(posedge clk) disable iff (!rst_n)
            starve[i] |-> (prio_a[i] == PRIO_W'(PRIO_MAX)))
            else $error("prio_aging_unit lane %0d: starve set below top priority", i);
`endif
    end

endmodule

// File: tb/tb_prio_aging_unit.sv
// Directed plus randomized bench for prio_aging_unit (AGE_THRESH = 4) against a rule-level model.
module tb_prio_aging_unit;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       age_en;
    logic [1:0] base_prio0, base_prio1, base_prio2;
    logic [2:0] req, gnt;
    logic [1:0] prio0, prio1, prio2;
    logic [2:0] starve;

    int checks = 0;
    int errors = 0;

    int m_cnt[3];
    int m_boost[3];
    int m_starve[3];
    int m_base[3];

    prio_aging_unit #(.AGE_THRESH(T), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .age_en     (age_en),
        .base_prio0 (base_prio0),
        .base_prio1 (base_prio1),
        .base_prio2 (base_prio2),
        .req        (req),
        .gnt        (gnt),
        .prio0      (prio0),
        .prio1      (prio1),
        .prio2      (prio2),
        .starve     (starve)
    );

    always #5 clk = ~clk;

    function automatic int m_prio(input int i);
        int s;
        s = m_base[i] + m_boost[i];
        return (s > 3) ? 3 : s;
    endfunction

    // Arbiter model: highest effective priority wins, ties go to the higher index.
    function automatic logic [2:0] m_arb(input logic [2:0] r);
        int best;
        best = -1;
        for (int i = 0; i < 3; i++)
            if (r[i] && (best < 0 || m_prio(i) >= m_prio(best))) best = i;
        return (best < 0) ? 3'b000 : 3'(1 << best);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_boost[i] = 0; m_starve[i] = 0;
        end
    endtask

    task automatic m_clock();
        for (int i = 0; i < 3; i++) begin
            if (gnt[i] || !req[i]) begin
                m_cnt[i] = 0; m_boost[i] = 0; m_starve[i] = 0;
            end else if (age_en) begin
                if (m_cnt[i] < T - 1) m_cnt[i]++;
                else begin
                    m_cnt[i] = 0;
                    if (m_prio(i) < 3) m_boost[i]++;
                    else m_starve[i] = 1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".prio0"}, 8'(prio0), 8'(m_prio(0)));
        check({tag, ".prio1"}, 8'(prio1), 8'(m_prio(1)));
        check({tag, ".prio2"}, 8'(prio2), 8'(m_prio(2)));
        check({tag, ".starve"}, 8'(starve), 8'(m_starve[0] + 2 * m_starve[1] + 4 * m_starve[2]));
    endtask

    // gmode 0: model arbiter drives gnt; otherwise gnt = gval.
    task automatic step(input logic [2:0] r, input logic en, input int b0, input int b1,
                        input int b2, input int gmode, input logic [2:0] gval);
        req = r; age_en = en;
        m_base[0] = b0; m_base[1] = b1; m_base[2] = b2;
        base_prio0 = 2'(b0); base_prio1 = 2'(b1); base_prio2 = 2'(b2);
        gnt = (gmode == 0) ? m_arb(r) : gval;
        #1;
        check("pre.prio0", 8'(prio0), 8'(m_prio(0)));
        check("pre.prio1", 8'(prio1), 8'(m_prio(1)));
        check("pre.prio2", 8'(prio2), 8'(m_prio(2)));
        @(posedge clk);
        m_clock();
        #1;
        check_model("post");
    endtask

    initial begin
        int b[3];
        logic [2:0] r;
        logic en;
        int gm;

        // Reset state: prio follows base with no clock edge.
        rst_n = 1'b0; age_en = 1'b1; req = 3'b000; gnt = 3'b000;
        base_prio0 = 2'd0; base_prio1 = 2'd2; base_prio2 = 2'd2;
        m_base[0] = 0; m_base[1] = 2; m_base[2] = 2;
        m_reset();
        #1;
        check("rst.prio0", 8'(prio0), 8'd0);
        check("rst.prio1", 8'(prio1), 8'd2);
        check("rst.prio2", 8'(prio2), 8'd2);
        check("rst.starve", 8'(starve), 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Requester 0 ages past requester 1 and finally wins.
        for (int e = 1; e <= 13; e++) begin
            step(3'b011, 1'b1, 0, 2, 2, 0, 3'b000);
            if (e == 4)  check("t2.prio0@4", 8'(prio0), 8'd1);
            if (e == 8)  check("t2.prio0@8", 8'(prio0), 8'd2);
            if (e == 12) check("t2.prio0@12", 8'(prio0), 8'd3);
            if (e == 13) check("t2.prio0@13", 8'(prio0), 8'd0);
        end

        // Lone requester never granted: saturates then flags starvation.
        for (int e = 1; e <= 12; e++) begin
            step(3'b001, 1'b1, 1, 2, 2, 1, 3'b000);
            if (e == 8)  check("t3.prio0@8", 8'(prio0), 8'd3);
            if (e == 11) check("t3.starve@11", 8'(starve), 8'd0);
            if (e == 12) check("t3.starve@12", 8'(starve), 8'd1);
        end
        step(3'b000, 1'b1, 1, 2, 2, 1, 3'b000);
        check("t3.drop.prio0", 8'(prio0), 8'd1);
        check("t3.drop.starve", 8'(starve), 8'd0);

        // Aging freeze mid-wait.
        for (int e = 1; e <= 6; e++) step(3'b001, 1'b1, 0, 2, 2, 1, 3'b000);
        check("t4.prio0.pre", 8'(prio0), 8'd1);
        for (int e = 1; e <= 10; e++) begin
            step(3'b001, 1'b0, 0, 2, 2, 1, 3'b000);
            check("t4.hold.prio0", 8'(prio0), 8'd1);
        end
        step(3'b001, 1'b1, 0, 2, 2, 1, 3'b000);
        check("t4.en1.prio0", 8'(prio0), 8'd1);
        step(3'b001, 1'b1, 0, 2, 2, 1, 3'b000);
        check("t4.en2.prio0", 8'(prio0), 8'd2);

        // Build boosts {2,1,1}, then assert reset between edges.
        step(3'b000, 1'b1, 1, 0, 1, 1, 3'b000);
        for (int e = 1; e <= 4; e++) step(3'b100, 1'b1, 1, 0, 1, 1, 3'b000);
        for (int e = 1; e <= 4; e++) step(3'b111, 1'b1, 1, 0, 1, 1, 3'b000);
        check("t5.pre.prio0", 8'(prio0), 8'd2);
        check("t5.pre.prio1", 8'(prio1), 8'd1);
        check("t5.pre.prio2", 8'(prio2), 8'd3);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check("t5.async.prio0", 8'(prio0), 8'd1);
        check("t5.async.prio1", 8'(prio1), 8'd0);
        check("t5.async.prio2", 8'(prio2), 8'd1);
        check("t5.async.starve", 8'(starve), 8'd0);
        @(posedge clk);
        #1;
        check_model("t5.held");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with persistent requests so lanes really age.
        r = 3'b111; en = 1'b1;
        b[0] = 0; b[1] = 1; b[2] = 2;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 9) == 0) b[i] = int'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
            end
            en = ($urandom_range(0, 9) != 0);
            gm = int'($urandom_range(0, 19));
            if (gm < 12)      step(r, en, b[0], b[1], b[2], 0, 3'b000);
            else if (gm < 19) step(r, en, b[0], b[1], b[2], 1, 3'b000);
            else              step(r, en, b[0], b[1], b[2], 1, 3'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_aging_unit.md
Name: prio_aging_unit

Overview:
- Upstream stage of the 3-requester, 4-level combinational priority arbiter.
- Takes static base priorities and raises each waiting requester's effective priority by one level per AGE_THRESH cycles of unserved waiting. This guarantees eventual service.
- The prio0/1/2 outputs drive the arbiter's priority inputs. The arbiter's gnt feeds back into this block.

Parameters:
- AGE_THRESH, 8, number of consecutive waiting cycles per one-level boost; legal range 1..255.
- CNT_W, 8, wait-counter width; must satisfy 2**CNT_W >= AGE_THRESH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- age_en  input  1  aging enable; when low, counters and boosts hold.
- base_prio0  input  2  base priority, requester 0 (3 = highest).
- base_prio1  input  2  base priority, requester 1.
- base_prio2  input  2  base priority, requester 2.
- req  input  3  request lines; bit i = requester i.
- gnt  input  3  grant vector fed back from the arbiter; zero or one-hot.
- prio0  output  2  effective priority to arbiter, requester 0.
- prio1  output  2  effective priority, requester 1.
- prio2  output  2  effective priority, requester 2.
- starve  output  3  bit i high: requester i is at level 3 and has waited another full AGE_THRESH without grant.

Behaviour:
- Per requester i, the block holds three registers: cnt_i (CNT_W bits), boost_i (2 bits) and starve_i.
- prio_i = min(base_prio_i + boost_i, 3).
  - Computed combinationally from registered boost_i and live base_prio_i.
  - A change in base_prio_i is visible on prio_i in the same cycle.
  - The sum is formed 3 bits wide, then saturated.
- Reset (rst_n low, asynchronous):
  - cnt_i = 0, boost_i = 0, starve_i = 0.
  - Hence prio_i = base_prio_i and starve = 3'b000.
  - Release is synchronous to clk.
- Per-cycle update, evaluated in priority order:
  1. gnt[i] = 1: cnt_i <= 0, boost_i <= 0, starve_i <= 0. Applies whether or not req[i] is set.
  2. req[i] = 0: cnt_i <= 0, boost_i <= 0, starve_i <= 0. A withdrawn request loses its accumulated age.
  3. age_en = 0: all three registers hold.
  4. cnt_i < AGE_THRESH-1: cnt_i <= cnt_i + 1.
  5. Otherwise (threshold reached):
     - cnt_i <= 0.
     - If prio_i < 3: boost_i <= boost_i + 1.
     - Else: starve_i <= 1. The flag is sticky until rule 1 or rule 2 clears it.
- Latency:
  - First boost appears on prio_i AGE_THRESH clock edges after req[i] rises, given continuous wait and age_en high.
  - With AGE_THRESH = 1, the boost rises every waiting cycle.
- boost_i never exceeds 3. Once prio_i = 3 it stops incrementing.
  - If base_prio_i later drops, the next threshold hit increments boost_i again.
- Lanes are independent. Simultaneous grant to lane j and threshold hit on lane k are both applied in the same cycle.
- The block does not check that gnt is one-hot. It applies rule 1 to every set bit.
- Reset asserted mid-wait discards all age immediately, with no clock edge needed.

Optional Feature:
- Macro: PRIO_AGING_ASSERT_EN.
- Defined: simulation-only concurrent assertions, evaluated while rst_n is high:
  - gnt is zero or one-hot.
  - gnt[i] implies req[i].
  - boost_i <= 3 and cnt_i < AGE_THRESH.
  - starve[i] implies prio_i == 3.
  - Each failure reports its lane index.
- Undefined: no assertion code. Synthesized logic is identical in both builds.

Decomposition:
- Shared package prio_aging_pkg contains:
  - Constant NREQ = 3.
  - Constant PRIO_W = 2.
  - Constant PRIO_MAX = 3.
  - Typedef prio_t (PRIO_W bits).
  - Function prio_sat_add(base, boost) returning prio_t.
- One sub-module, prio_age_lane.
  - Holds cnt, boost, starve and the update rules for a single requester.
  - Instantiated three times by the top.
  - The top only wires lanes and drives outputs.

Test Plan (AGE_THRESH = 4; bench drives gnt from a behavioural model of the arbiter):
1. Reset, base = {2,2,0} for requesters {2,1,0}, req = 3'b000 -> prio0..2 = 0,2,2; starve = 000.
2. base0 = 0, base1 = 2, req = 3'b011 held -> gnt = 010 each cycle.
   - prio0 = 1 after 4 edges and 2 after 8 edges; the model still grants requester 1 on the tie.
   - prio0 = 3 after 12 edges; the model then grants requester 0.
   - Next edge: prio0 = 0.
3. req0 alone with gnt forced 000, base0 = 1:
   - prio0 reaches 3 after 8 edges.
   - starve[0] = 1 after 12 edges.
   - Dropping req0 clears prio0 to 1 and starve[0] to 0 on the next edge.
4. Mid-wait with boost0 = 1, cnt0 = 2, drive age_en = 0 for 10 cycles -> prio0 and cnt0 unchanged. Re-enable -> boost to 2 after 2 more edges.
5. Assert rst_n low asynchronously between edges while boost = {2,1,1} -> prio equals base immediately; starve = 000.
6. With PRIO_AGING_ASSERT_EN defined, drive gnt = 3'b011 -> assertion fires naming lanes 0 and 1; both lanes still clear per rule 1.
